// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FETCH_HALT_DETECT_EN enables HALT_OPCODE detection in instr_fetch_unit.
package fetch_pkg;

    localparam int PC_W    = 6;
    localparam int INSTR_W = 16;

    localparam logic [INSTR_W-1:0] HALT_OPCODE = 16'hFFFF;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous prefetch FIFO with flush. When full, a push is
// still accepted if a pop happens in the same cycle (write-through).
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         empty,
    output logic         full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign rdata   = mem[rptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_W'(1);
            if (do_pop)  rptr <= rptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is not reset; count gates visibility, so stale contents
    // are never presented and the array can map onto plain registers/RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter, redirect FSM and prefetch buffer feeding decode.
// Define FETCH_HALT_DETECT_EN to stop fetching after HALT_OPCODE (adds port halted).
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
`ifdef FETCH_HALT_DETECT_EN
    output logic               halted,
`endif
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [PC_W-1:0]    dec_pc
);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [PC_W-1:0] pc;
    fetch_entry_t    head;
    fetch_entry_t    wr_entry;
    logic            fifo_empty;
    logic            fifo_full;
    logic            pop;
    logic            fetch;
    logic            stop;

    assign imem_addr = pc;
    assign dec_valid = ~fifo_empty & (state == FETCH);
    assign pop       = dec_valid & dec_ready;
    assign fetch     = ~redirect_valid & (~fifo_full | pop) & ~stop;
    assign dec_instr = dec_valid ? head.instr : '0;
    assign dec_pc    = dec_valid ? head.pc    : '0;
    assign wr_entry  = '{pc: pc, instr: imem_data};

`ifdef FETCH_HALT_DETECT_EN
    // Halt sticks until a redirect; queued instructions still drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                halted <= 1'b0;
        else if (redirect_valid)                   halted <= 1'b0;
        else if (fetch && imem_data == HALT_OPCODE) halted <= 1'b1;
    end
    assign stop = halted;
`else
    assign stop = 1'b0;
`endif

    // Redirect wins over fetch; PC wraps naturally at 2^PC_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              pc <= RESET_PC;
        else if (redirect_valid) pc <= redirect_pc;
        else if (fetch)          pc <= pc + PC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_next;
    end

    // NOTE: next-state defaults to the current state before the case, so
    // no path leaves state_next unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (redirect_valid) state_next = FLUSH;
            FLUSH:   state_next = redirect_valid ? FLUSH : FETCH;
            default: state_next = FETCH;
        endcase
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (fetch),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a scoreboard queue
// of expected {pc, instr} pairs; halt tests run when FETCH_HALT_DETECT_EN is set.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [5:0]  redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] dec_instr;
    logic [5:0]  dec_pc;
`ifdef FETCH_HALT_DETECT_EN
    logic        halted;
`endif

    logic [15:0] mem [64];
    logic [21:0] sb [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    instr_fetch_unit #(
        .DEPTH    (2),
        .RESET_PC (6'd0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef FETCH_HALT_DETECT_EN
        .halted         (halted),
`endif
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Push n sequential fetches starting at start (wrapping), instr = 0x1000 + pc.
    task automatic expect_run(input logic [5:0] start, input int n);
        logic [5:0] p;
        for (int i = 0; i < n; i++) begin
            p = start + 6'(i);
            sb.push_back({p, 16'h1000 + 16'(p)});
        end
    endtask

    // Called at a negedge: hold dec_ready high until n transfers are seen,
    // comparing each against the scoreboard; then drop dec_ready next negedge.
    task automatic stream(input int n, input int exp_cycles);
        int          accepted = 0;
        int          cycles   = 0;
        logic [21:0] e;
        dec_ready = 1'b1;
        while (accepted < n && cycles < 50) begin
            cycles++;
            if (dec_valid && sb.size() > 0) begin
                e = sb.pop_front();
                check("dec_pc", 32'(dec_pc), 32'(e[21:16]));
                check("dec_instr", 32'(dec_instr), 32'(e[15:0]));
                accepted++;
            end
            if (accepted < n) @(negedge clk);
        end
        check("stream_count", accepted, n);
        check("stream_cycles", cycles, exp_cycles);
        sb.delete();
        @(negedge clk);
        dec_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i);
        rst_n          = 1'b0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 6'd0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_dec_valid", 32'(dec_valid), 0);
        check("rst_dec_instr", 32'(dec_instr), 0);
        check("rst_dec_pc", 32'(dec_pc), 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        rst_n = 1'b1;
        check("rel_dec_valid", 32'(dec_valid), 0);
        @(negedge clk);
        check("first_valid", 32'(dec_valid), 1);
        check("first_pc", 32'(dec_pc), 0);

        // Stall: FIFO fills with pc 0,1 and PC holds at 2
        repeat (4) begin
            @(negedge clk);
            check("stall_addr", 32'(imem_addr), 2);
            check("stall_instr", 32'(dec_instr), 32'h1000);
            check("stall_pc", 32'(dec_pc), 0);
        end
        expect_run(6'd0, 6);
        stream(6, 6);
        check("post_run_pc", 32'(dec_pc), 6);
        check("post_run_addr", 32'(imem_addr), 8);

        // Redirect with full FIFO and dec_ready high: pop is void
        redirect_valid = 1'b1;
        redirect_pc    = 6'h20;
        dec_ready      = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        dec_ready      = 1'b0;
        check("flush_valid", 32'(dec_valid), 0);
        check("flush_pc", 32'(dec_pc), 0);
        check("flush_addr", 32'(imem_addr), 32'h20);
        @(negedge clk);
        expect_run(6'h20, 4);
        stream(4, 4);

        // Back-to-back redirects, last wins; then PC wrap 3E,3F,00,01
        redirect_valid = 1'b1;
        redirect_pc    = 6'h10;
        @(negedge clk);
        redirect_pc    = 6'h3E;
        check("b2b_valid", 32'(dec_valid), 0);
        @(negedge clk);
        redirect_valid = 1'b0;
        check("b2b_valid2", 32'(dec_valid), 0);
        check("b2b_addr", 32'(imem_addr), 32'h3E);
        @(negedge clk);
        expect_run(6'h3E, 4);
        stream(4, 4);

        // Async reset with a full FIFO, away from any clock edge
        @(negedge clk);
        check("full_valid", 32'(dec_valid), 1);
        check("full_addr", 32'(imem_addr), 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(dec_valid), 0);
        check("async_addr", 32'(imem_addr), 0);
        check("async_instr", 32'(dec_instr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rerel_valid", 32'(dec_valid), 0);
        @(negedge clk);
        expect_run(6'd0, 3);
        stream(3, 3);

`ifdef FETCH_HALT_DETECT_EN
        mem[3]         = 16'hFFFF;
        redirect_valid = 1'b1;
        redirect_pc    = 6'd0;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("halt_clear0", 32'(halted), 0);
        @(negedge clk);
        expect_run(6'd0, 3);
        sb.push_back({6'd3, 16'hFFFF});
        stream(4, 4);
        check("halted_set", 32'(halted), 1);
        check("halt_addr", 32'(imem_addr), 4);
        check("halt_drained", 32'(dec_valid), 0);
        @(negedge clk);
        check("halt_addr_hold", 32'(imem_addr), 4);
        redirect_valid = 1'b1;
        redirect_pc    = 6'd0;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("halt_cleared", 32'(halted), 0);
        @(negedge clk);
        check("resume_valid", 32'(dec_valid), 1);
        check("resume_pc", 32'(dec_pc), 0);
        mem[3] = 16'h1003;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
